pipe_stage_regs: RTL and testbench

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

---
 rtl/pipe_stage_regs.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipe_stage_regs.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//
// Pipeline registers for the ID->EX, EX->MEM and MEM->WB boundaries of a
// five-stage MIPS-style core, together with the ID-stage operand forwarding
// muxes and the EX-stage jal result/destination override.
//
// Optional build macro: PIPE_STATS_EN
//   defined   -> 16-bit saturating stall and forwarding counters are built.
//   undefined -> stall_cnt and fwd_cnt are tied to 0.
//
// Ports
//   clock, reset          : sole clock (rising edge), asynchronous active-high reset
//   wreg..shift, aluc     : ID-stage controls (already zero during a stall)
//   wpcir                 : 0 marks a load-use stall cycle (inserts a bubble)
//   fwda, fwdb            : operand source select
//                           00 regfile, 01 EX result, 10 MEM ALU result, 11 MEM load data
//   qa, qb, imm, pc4, rn  : ID-stage data and destination register
//   alu_r                 : raw ALU output of the EX instruction
//   mmo                   : data-RAM read data of the MEM instruction
//   fa, fb, rsrtequ       : forwarded ID operands and their equality (combinational)
//   ea..ewmem             : EX-stage registers
//   ealu, ern             : EX result and destination (jal-adjusted)
//   malu..mwmem           : MEM-stage registers
//   wrn, wwreg, wdi       : WB destination, write enable and write data
//   stall_cnt, fwd_cnt    : statistics counters
// ---------------------------------------------------------------------------
module pipe_stage_regs (
    input  logic        clock,
    input  logic        reset,
    // ID-stage controls
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic        jal,
    input  logic        aluimm,
    input  logic        shift,
    input  logic [3:0]  aluc,
    input  logic        wpcir,
    input  logic [1:0]  fwda,
    input  logic [1:0]  fwdb,
    // ID-stage data
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    input  logic [31:0] imm,
    input  logic [31:0] pc4,
    input  logic [4:0]  rn,
    // EX / MEM feedback
    input  logic [31:0] alu_r,
    input  logic [31:0] mmo,
    // forwarded operands
    output logic [31:0] fa,
    output logic [31:0] fb,
    output logic        rsrtequ,
    // EX stage
    output logic [31:0] ea,
    output logic [31:0] eb,
    output logic [31:0] eimm,
    output logic [31:0] epc4,
    output logic [3:0]  ealuc,
    output logic        ealuimm,
    output logic        eshift,
    output logic        ejal,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [31:0] ealu,
    output logic [4:0]  ern,
    // MEM stage
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    // WB stage
    output logic [4:0]  wrn,
    output logic        wwreg,
    output logic [31:0] wdi,
    // statistics
    output logic [15:0] stall_cnt,
    output logic [15:0] fwd_cnt
);

    // -----------------------------------------------------------------------
    // ID-stage operand forwarding. Both operands share the same mux shape,
    // so one generate loop builds A (index 0) and B (index 1).
    // -----------------------------------------------------------------------
    logic [31:0] q_src   [2];
    logic [1:0]  fwd_sel [2];
    logic [31:0] f_out   [2];

    assign q_src[0]   = qa;
    assign q_src[1]   = qb;
    assign fwd_sel[0] = fwda;
    assign fwd_sel[1] = fwdb;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                f_out[gi] = q_src[gi];
                case (fwd_sel[gi])
                    2'b00:   f_out[gi] = q_src[gi];
                    2'b01:   f_out[gi] = ealu;
                    2'b10:   f_out[gi] = malu;
                    2'b11:   f_out[gi] = mmo;
                    default: f_out[gi] = q_src[gi];
                endcase
            end
        end
    endgenerate

    assign fa      = f_out[0];
    assign fb      = f_out[1];
    assign rsrtequ = (f_out[0] == f_out[1]);

    // -----------------------------------------------------------------------
    // ID -> EX
    // The raw destination is kept separately; ern applies the jal override
    // so the bubble logic only has to clear ejal for the override to vanish.
    // -----------------------------------------------------------------------
    logic [4:0] ern_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            epc4    <= '0;
            ern_reg <= '0;
            ealuc   <= '0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ejal    <= 1'b0;
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
        end else begin
            ea      <= fa;
            eb      <= fb;
            eimm    <= imm;
            epc4    <= pc4;
            ern_reg <= rn;
            ealuc   <= aluc;
            ealuimm <= aluimm;
            eshift  <= shift;
            // Bubble on a stall cycle: state-changing controls are forced low
            // even if the control unit did not already zero them.
            ejal    <= wpcir & jal;
            ewreg   <= wpcir & wreg;
            em2reg  <= wpcir & m2reg;
            ewmem   <= wpcir & wmem;
        end
    end

    // jal writes its return address (PC+8 of the jal, i.e. pc4+4) into r31.
    // The add wraps naturally at 32 bits.
    assign ealu = ejal ? (epc4 + 32'd4) : alu_r;
    assign ern  = ejal ? 5'd31 : ern_reg;

    // -----------------------------------------------------------------------
    // EX -> MEM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            malu   <= '0;
            mb     <= '0;
            mrn    <= '0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
        end else begin
            malu   <= ealu;
            mb     <= eb;
            mrn    <= ern;
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
        end
    end

    // -----------------------------------------------------------------------
    // MEM -> WB
    // r0 destinations pass through untouched; the register file drops them.
    // -----------------------------------------------------------------------
    logic [31:0] walu;
    logic [31:0] wmo;
    logic        wm2reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            walu   <= '0;
            wmo    <= '0;
            wrn    <= '0;
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else begin
            walu   <= malu;
            wmo    <= mmo;
            wrn    <= mrn;
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
        end
    end

    assign wdi = wm2reg ? wmo : walu;

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] fwd_cnt_reg;
    logic        stall_evt;
    logic        fwd_evt;

    assign stall_evt = ~wpcir;
    assign fwd_evt   = (fwda != 2'b00) | (fwdb != 2'b00);

    // Counters stick at all-ones rather than wrapping so a long run still
    // reads as "at least this many".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (stall_evt && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (fwd_evt && (fwd_cnt_reg != 16'hFFFF))
                fwd_cnt_reg <= fwd_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`else
    assign stall_cnt = 16'd0;
    assign fwd_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_regs
//
// Directed self-checking bench for pipe_stage_regs. Inputs are driven and
// outputs sampled 2 time units after each rising edge. Expected values are
// hand-computed constants. Counter checks depend on PIPE_STATS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic        wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0]  aluc;
    logic        wpcir;
    logic [1:0]  fwda, fwdb;
    logic [31:0] qa, qb, imm, pc4;
    logic [4:0]  rn;
    logic [31:0] alu_r, mmo;
    logic [31:0] fa, fb;
    logic        rsrtequ;
    logic [31:0] ea, eb, eimm, epc4;
    logic [3:0]  ealuc;
    logic        ealuimm, eshift, ejal, ewreg, em2reg, ewmem;
    logic [31:0] ealu;
    logic [4:0]  ern;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  wrn;
    logic        wwreg;
    logic [31:0] wdi;
    logic [15:0] stall_cnt, fwd_cnt;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    pipe_stage_regs dut (
        .clock     (clock),
        .reset     (reset),
        .wreg      (wreg),
        .m2reg     (m2reg),
        .wmem      (wmem),
        .jal       (jal),
        .aluimm    (aluimm),
        .shift     (shift),
        .aluc      (aluc),
        .wpcir     (wpcir),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .qa        (qa),
        .qb        (qb),
        .imm       (imm),
        .pc4       (pc4),
        .rn        (rn),
        .alu_r     (alu_r),
        .mmo       (mmo),
        .fa        (fa),
        .fb        (fb),
        .rsrtequ   (rsrtequ),
        .ea        (ea),
        .eb        (eb),
        .eimm      (eimm),
        .epc4      (epc4),
        .ealuc     (ealuc),
        .ealuimm   (ealuimm),
        .eshift    (eshift),
        .ejal      (ejal),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ewmem     (ewmem),
        .ealu      (ealu),
        .ern       (ern),
        .malu      (malu),
        .mb        (mb),
        .mrn       (mrn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .wrn       (wrn),
        .wwreg     (wwreg),
        .wdi       (wdi),
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic id_nop();
        wreg = 0; m2reg = 0; wmem = 0; jal = 0; aluimm = 0; shift = 0;
        aluc = 4'h0; wpcir = 1; fwda = 2'b00; fwdb = 2'b00;
        qa = 0; qb = 0; imm = 0; pc4 = 0; rn = 5'd0;
    endtask

    initial begin
        id_nop();
        alu_r = 32'h0000ABCD;
        mmo   = 32'h0;
        reset = 1'b1;
        #2;
        // reset state, before any clock edge
        chk("rst_ewreg", {31'b0, ewreg}, 32'h0);
        chk("rst_ern",   {27'b0, ern},   32'h0);
        chk("rst_ealu",  ealu,           32'h0000ABCD);
        chk("rst_wdi",   wdi,            32'h0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'h0);
        step();
        step();
        reset = 1'b0;

        // add r3: qa=5, qb=7, rn=3, wreg=1
        wreg = 1; rn = 5'd3; qa = 32'd5; qb = 32'd7; aluc = 4'h2;
        #1;
        chk("add_fa",    fa,                 32'd5);
        chk("add_eq0",   {31'b0, rsrtequ},   32'h0);
        step();
        chk("add_ern",   {27'b0, ern},       32'd3);
        chk("add_ewreg", {31'b0, ewreg},     32'h1);
        chk("add_eb",    eb,                 32'd7);
        id_nop();
        alu_r = 32'd12;
        step();
        chk("add_malu",  malu,               32'd12);
        alu_r = 32'd0;
        step();
        chk("add_wdi",   wdi,                32'd12);
        chk("add_wrn",   {27'b0, wrn},       32'd3);
        chk("add_wwreg", {31'b0, wwreg},     32'h1);

        // forwarding: ealu=0x11, malu=0x22, mmo=0x33
        alu_r = 32'h22;
        step();
        alu_r = 32'h11; mmo = 32'h33; qa = 32'h0; qb = 32'h77;
        fwda = 2'b01; #1; chk("fwd_a01", fa, 32'h11);
        fwda = 2'b10; #1; chk("fwd_a10", fa, 32'h22);
        fwda = 2'b11; #1; chk("fwd_a11", fa, 32'h33);
        chk("fwd_b00", fb, 32'h77);
        fwda = 2'b00; qa = 32'h77; #1;
        chk("eq_same",  {31'b0, rsrtequ}, 32'h1);
        qa = 32'h80000077; #1;
        chk("eq_msb",   {31'b0, rsrtequ}, 32'h0);
        id_nop(); mmo = 32'h0; alu_r = 32'h0;

        // jal with pc4=0x1000; rn is overridden to 31
        jal = 1; wreg = 1; pc4 = 32'h1000; rn = 5'd5;
        step();
        chk("jal_ern",  {27'b0, ern}, 32'd31);
        chk("jal_ealu", ealu,         32'h1004);
        id_nop();
        step();
        step();
        chk("jal_wdi",  wdi,          32'h1004);
        chk("jal_wrn",  {27'b0, wrn}, 32'd31);
        chk("jal_wwreg",{31'b0, wwreg}, 32'h1);
        jal = 1; wreg = 1; pc4 = 32'hFFFFFFFC;
        step();
        chk("jal_wrap", ealu, 32'h0);
        id_nop();
        step();

        // two consecutive stall cycles with controls presented
        wreg = 1; m2reg = 1; wmem = 1; jal = 1; rn = 5'd7; wpcir = 0;
        step();
        chk("stl1_ewreg", {31'b0, ewreg},  32'h0);
        chk("stl1_ejal",  {31'b0, ejal},   32'h0);
        chk("stl1_ewmem", {31'b0, ewmem},  32'h0);
        chk("stl1_ern",   {27'b0, ern},    32'd7);
        step();
        chk("stl2_ewreg", {31'b0, ewreg},  32'h0);
        chk("stl2_mwreg", {31'b0, mwreg},  32'h0);
        id_nop();
        step();
        chk("stl3_mwreg", {31'b0, mwreg},  32'h0);
        chk("stl3_mwmem", {31'b0, mwmem},  32'h0);
        chk("stl3_wwreg", {31'b0, wwreg},  32'h0);
        step();
        chk("stl4_wwreg", {31'b0, wwreg},  32'h0);
`ifdef PIPE_STATS_EN
        chk("stall_cnt2", {16'b0, stall_cnt}, 32'd2);
        chk("fwd_cnt0",   {16'b0, fwd_cnt},   32'd0);
`else
        chk("stall_tied", {16'b0, stall_cnt}, 32'd0);
        chk("fwd_tied",   {16'b0, fwd_cnt},   32'd0);
`endif

        // mid-run reset with write-enabled instructions in every stage
        wreg = 1; rn = 5'd9; qa = 32'h55; alu_r = 32'h66;
        step();
        step();
        step();
        chk("pre_wwreg", {31'b0, wwreg}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_ewreg", {31'b0, ewreg}, 32'h0);
        chk("mr_mwreg", {31'b0, mwreg}, 32'h0);
        chk("mr_wwreg", {31'b0, wwreg}, 32'h0);
        chk("mr_ern",   {27'b0, ern},   32'h0);
        chk("mr_malu",  malu,           32'h0);
        chk("mr_wdi",   wdi,            32'h0);
        chk("mr_ealu",  ealu,           32'h66);
        reset = 1'b0;
        rn = 5'd4; qa = 32'h99;
        step();
        chk("post_ern",   {27'b0, ern},   32'd4);
        chk("post_ea",    ea,             32'h99);
        chk("post_ewreg", {31'b0, ewreg}, 32'h1);
        chk("post_mwreg", {31'b0, mwreg}, 32'h0);
`ifdef PIPE_STATS_EN
        chk("post_stall", {16'b0, stall_cnt}, 32'd0);

        // forwarding counter saturation
        id_nop();
        fwda = 2'b01;
        for (int i = 0; i < 70000; i++) @(posedge clock);
        #2;
        chk("fwd_sat",  {16'b0, fwd_cnt}, 32'h0000FFFF);
        step();
        step();
        chk("fwd_hold", {16'b0, fwd_cnt}, 32'h0000FFFF);
        fwda = 2'b00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
